// File: rtl/uart_alu_frame_ctrl.sv
// uart_alu_frame_ctrl: framed UART byte-stream command processor feeding and reading a parametrised ALU
// Ports: clk/reset (async, active-high); rx_empty/rx_data/rx_rd = RX FIFO pop side (first-word fall-through);
// tx_full/tx_wr/tx_data = TX FIFO push side; alu_a/alu_b/alu_op = committed ALU inputs; alu_result = ALU output;
// busy = not idle; err_opcode/err_timeout = one-cycle error pulses.
module uart_alu_frame_ctrl #(
  parameter int DATA_W = 16,
  parameter int OP_W = 6,
  parameter int TIMEOUT = 50000,
  parameter int TO_W = 16,
  parameter logic [7:0] OPC_A = 8'h61,
  parameter logic [7:0] OPC_B = 8'h62,
  parameter logic [7:0] OPC_OP = 8'h63,
  parameter logic [7:0] OPC_EXEC = 8'h64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_empty,
  input  logic [7:0]        rx_data,
  output logic              rx_rd,
  input  logic              tx_full,
  output logic              tx_wr,
  output logic [7:0]        tx_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result,
  output logic              busy,
  output logic              err_opcode,
  output logic              err_timeout
);
  localparam int NB = DATA_W / 8;
  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;
  typedef enum logic [1:0] {T_A, T_B, T_OP} target_t;
  state_t state;
  target_t target;
  logic [2:0] remaining, sent;
  logic [DATA_W-1:0] asm_r, shift, nxt_asm;
  logic [TO_W-1:0] to_cnt;
  assign rx_rd = (state == IDLE || state == LOAD) && !rx_empty;
  assign tx_wr = state == SEND && !tx_full;
  assign tx_data = shift[7:0];
  assign busy = state != IDLE;
  // bytes enter at the top and move down, so after NB pops the first byte sits in the low lane
  always_comb begin
    nxt_asm = asm_r >> 8;
    nxt_asm[DATA_W-1 -: 8] = rx_data;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      target <= T_A;
      remaining <= '0;
      sent <= '0;
      asm_r <= '0;
      shift <= '0;
      to_cnt <= '0;
      alu_a <= '0;
      alu_b <= '0;
      alu_op <= '0;
      err_opcode <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      err_opcode <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        IDLE: if (rx_rd) begin
          if (rx_data == OPC_A || rx_data == OPC_B) begin
            target <= rx_data == OPC_A ? T_A : T_B;
            remaining <= 3'(NB);
            asm_r <= '0;
            to_cnt <= '0;
            state <= LOAD;
          end else if (rx_data == OPC_OP) begin
            target <= T_OP;
            remaining <= 3'd1;
            asm_r <= '0;
            to_cnt <= '0;
            state <= LOAD;
          end else if (rx_data == OPC_EXEC) begin
            shift <= alu_result;
            sent <= '0;
            state <= SEND;
          end else
            err_opcode <= 1'b1;
        end
        LOAD: if (rx_rd) begin
          to_cnt <= '0;
          remaining <= remaining - 3'd1;
          asm_r <= nxt_asm;
          if (remaining == 3'd1) begin
            state <= IDLE;
            if (target == T_A) alu_a <= nxt_asm;
            if (target == T_B) alu_b <= nxt_asm;
            if (target == T_OP) alu_op <= rx_data[OP_W-1:0];
          end
        end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
          err_timeout <= 1'b1;
          asm_r <= '0;
          to_cnt <= '0;
          state <= IDLE;
        end else
          to_cnt <= to_cnt + 1'b1;
        SEND: if (tx_wr) begin
          shift <= shift >> 8;
          sent <= sent + 3'd1;
          if (sent == 3'(NB - 1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_alu_frame_ctrl.sv
// tb_uart_alu_frame_ctrl: scoreboard bench for uart_alu_frame_ctrl (DATA_W=16, TIMEOUT=10)
module tb_uart_alu_frame_ctrl;
  logic clk = 0, reset = 1, rx_empty, rx_rd, tx_full = 0, tx_wr, busy, err_opcode, err_timeout;
  logic [7:0] rx_data, tx_data;
  logic [15:0] alu_a, alu_b, alu_result = 0;
  logic [5:0] alu_op;
  logic [7:0] mem [256];
  logic [7:0] wr_ptr = 0, rd_ptr = 0;
  logic [7:0] exp_q [$];
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  assign rx_empty = wr_ptr == rd_ptr;
  assign rx_data = mem[rd_ptr];
  always @(posedge clk) if (rx_rd && !rx_empty) rd_ptr <= rd_ptr + 8'd1;
  uart_alu_frame_ctrl #(.DATA_W(16), .OP_W(6), .TIMEOUT(10), .TO_W(16)) dut (
    .clk(clk), .reset(reset), .rx_empty(rx_empty), .rx_data(rx_data), .rx_rd(rx_rd),
    .tx_full(tx_full), .tx_wr(tx_wr), .tx_data(tx_data), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .alu_result(alu_result), .busy(busy), .err_opcode(err_opcode),
    .err_timeout(err_timeout));
  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 8'd1;
  endtask
  task automatic test_reset;
    @(negedge clk);
    checks++; if ({alu_a, alu_b, alu_op} !== '0) begin failures++; $display("FAIL reset_regs got %h/%h/%h want 0", alu_a, alu_b, alu_op); end
    checks++; if ({busy, rx_rd, tx_wr, err_opcode, err_timeout} !== 5'b0) begin failures++; $display("FAIL reset_flags got %b want 00000", {busy, rx_rd, tx_wr, err_opcode, err_timeout}); end
    reset = 0;
    @(negedge clk);
  endtask
  task automatic test_load_a;
    push(8'h61); push(8'h34); push(8'h12);
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (rx_rd !== 1'b1) begin failures++; $display("FAIL load_a_rd%0d got %b want 1", i, rx_rd); end
      if (i == 2) begin checks++; if (alu_a !== 16'h0) begin failures++; $display("FAIL load_a_partial got %h want 0000", alu_a); end end
      @(negedge clk);
    end
    checks++; if (alu_a !== 16'h1234) begin failures++; $display("FAIL load_a got %h want 1234", alu_a); end
    checks++; if (busy !== 1'b0 || rx_rd !== 1'b0) begin failures++; $display("FAIL load_a_idle got busy=%b rd=%b want 0 0", busy, rx_rd); end
  endtask
  task automatic test_load_b_opcode_data;
    int errs = 0;
    push(8'h62); push(8'h61); push(8'h62);
    repeat (5) begin @(negedge clk); if (err_opcode) errs++; end
    checks++; if (alu_b !== 16'h6261) begin failures++; $display("FAIL load_b got %h want 6261", alu_b); end
    checks++; if (errs != 0) begin failures++; $display("FAIL load_b_err got %0d pulses want 0", errs); end
  endtask
  task automatic test_op_exec;
    int first = -1, last = -1;
    logic [7:0] e;
    alu_result = 16'hBEEF;
    push(8'h63); push(8'hFF); push(8'h64);
    exp_q.push_back(8'hEF); exp_q.push_back(8'hBE);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
      #1;
      if (tx_wr) begin
        e = exp_q.pop_front();
        checks++; if (tx_data !== e) begin failures++; $display("FAIL exec_byte got %h want %h", tx_data, e); end
        if (first < 0) first = i;
        last = i;
      end
      @(negedge clk);
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL exec_drain got %0d left want 0", exp_q.size()); exp_q.delete(); end
    checks++; if (last - first != 1) begin failures++; $display("FAIL exec_b2b got gap %0d want 1", last - first); end
    #1;
    checks++; if (busy !== 1'b0 || tx_wr !== 1'b0) begin failures++; $display("FAIL exec_done got busy=%b wr=%b want 0 0", busy, tx_wr); end
    checks++; if (alu_op !== 6'h3F) begin failures++; $display("FAIL exec_op got %h want 3f", alu_op); end
    @(negedge clk);
  endtask
  task automatic test_stall;
    int wrs = 0, tos = 0;
    logic [7:0] e;
    tx_full = 1;
    alu_result = 16'h1357;
    push(8'h64);
    exp_q.push_back(8'h57); exp_q.push_back(8'h13);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx_wr) wrs++;
      if (err_timeout) tos++;
      if (i == 10) alu_result = 16'hFFFF;
    end
    checks++; if (wrs != 0 || tos != 0) begin failures++; $display("FAIL stall got wr=%0d to=%0d want 0 0", wrs, tos); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL stall_busy got %b want 1", busy); end
    tx_full = 0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      #1;
      if (tx_wr) begin
        e = exp_q.pop_front();
        checks++; if (tx_data !== e) begin failures++; $display("FAIL stall_byte got %h want %h", tx_data, e); end
      end
      @(negedge clk);
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL stall_drain got %0d left want 0", exp_q.size()); exp_q.delete(); end
  endtask
  task automatic test_timeout;
    int pulses = 0, at = -1;
    push(8'h61); push(8'hAA);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (err_timeout) begin pulses++; if (at < 0) at = i; end
    end
    checks++; if (pulses != 1) begin failures++; $display("FAIL timeout_pulse got %0d cycles want 1", pulses); end
    checks++; if (at < 11 || at > 13) begin failures++; $display("FAIL timeout_when got cycle %0d want 11..13", at); end
    checks++; if (alu_a !== 16'h1234 || busy !== 1'b0) begin failures++; $display("FAIL timeout_keep got a=%h busy=%b want 1234 0", alu_a, busy); end
    push(8'h61); push(8'h01); push(8'h02);
    repeat (4) @(negedge clk);
    checks++; if (alu_a !== 16'h0201) begin failures++; $display("FAIL timeout_reload got %h want 0201", alu_a); end
    pulses = 0;
    push(8'h61);
    repeat (8) begin @(negedge clk); if (err_timeout) pulses++; end
    push(8'h11);
    repeat (8) begin @(negedge clk); if (err_timeout) pulses++; end
    push(8'h22);
    repeat (3) begin @(negedge clk); if (err_timeout) pulses++; end
    checks++; if (pulses != 0 || alu_a !== 16'h2211) begin failures++; $display("FAIL slow_frame got to=%0d a=%h want 0 2211", pulses, alu_a); end
  endtask
  task automatic test_bad_opcode;
    push(8'h7A);
    #1;
    checks++; if (rx_rd !== 1'b1) begin failures++; $display("FAIL bad_rd got %b want 1", rx_rd); end
    @(negedge clk);
    checks++; if (err_opcode !== 1'b1 || busy !== 1'b0 || rx_rd !== 1'b0) begin failures++; $display("FAIL bad_err got err=%b busy=%b rd=%b want 1 0 0", err_opcode, busy, rx_rd); end
    @(negedge clk);
    checks++; if (err_opcode !== 1'b0) begin failures++; $display("FAIL bad_pulse got %b want 0", err_opcode); end
  endtask
  task automatic test_reset_mid_send;
    logic [7:0] e;
    logic seen = 0;
    alu_result = 16'hA5C3;
    push(8'h64);
    exp_q.push_back(8'hC3);
    for (int i = 0; i < 10 && !seen; i++) begin
      #1;
      if (tx_wr) begin
        seen = 1;
        e = exp_q.pop_front();
        checks++; if (tx_data !== e) begin failures++; $display("FAIL rst_send_byte got %h want %h", tx_data, e); end
      end
      @(negedge clk);
    end
    checks++; if (!seen) begin failures++; $display("FAIL rst_send_start got no write want one"); exp_q.delete(); end
    checks++; if (tx_wr !== 1'b1) begin failures++; $display("FAIL rst_send_second got %b want 1", tx_wr); end
    reset = 1;
    #1;
    checks++; if (tx_wr !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rst_send_out got wr=%b busy=%b want 0 0", tx_wr, busy); end
    checks++; if ({alu_a, alu_b, alu_op} !== '0) begin failures++; $display("FAIL rst_send_regs got %h/%h/%h want 0", alu_a, alu_b, alu_op); end
    @(negedge clk);
    reset = 0;
    @(negedge clk);
  endtask
  initial begin
    test_reset;
    test_load_a;
    test_load_b_opcode_data;
    test_op_exec;
    test_stall;
    test_timeout;
    test_bad_opcode;
    test_reset_mid_send;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
